// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the regfile write-port arbiter: write request record,
// default aux FIFO depth and the arbitration state encoding.
package wb_port_arbiter_pkg;

    typedef logic [4:0]  rv32i_reg;
    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        rv32i_reg  rd;
        rv32i_word data;
    } wb_req_t;

    localparam int unsigned AUX_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_PEND  = 2'd1,
        ARB_FORCE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wb_aux_fifo.sv
// Small circular FIFO holding aux unit results until they win the regfile port.
// Pointers wrap modulo AUX_DEPTH; occupancy lives in its own counter.
module wb_aux_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter  int unsigned AUX_DEPTH = AUX_DEPTH_DEF,
    localparam int unsigned PTR_W     = (AUX_DEPTH > 1) ? $clog2(AUX_DEPTH) : 1,
    localparam int unsigned CNT_W     = $clog2(AUX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  wb_req_t          din,
    output wb_req_t          dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(AUX_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(AUX_DEPTH);

    wb_req_t          r_mem [AUX_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == {CNT_W{1'b0}});
    assign count     = r_count;
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;
    assign dout      = r_mem[r_rd_ptr];

    // Entry storage, written at the tail
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between the WB stage and queued aux results.
// Define WB_ARB_AGE_EN to enable the aging guard (age counter + FORCE state).
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned AUX_DEPTH = AUX_DEPTH_DEF,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        pipe_valid,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall,
    input  logic        aux_valid,
    input  logic [4:0]  aux_rd,
    input  logic [31:0] aux_data,
    output logic        aux_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data
);

    localparam int unsigned CNT_W = $clog2(AUX_DEPTH + 1);

    if (AUX_DEPTH < 1 || AUX_DEPTH > 8 || MAX_WAIT < 1) begin : g_param_check
        $error("wb_port_arbiter: AUX_DEPTH must be 1..8 and MAX_WAIT >= 1");
    end

    arb_state_e       r_state;
    wb_req_t          w_aux_req;
    wb_req_t          w_head;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_preq;
    logic             w_push;
    logic             w_pop;
    logic             w_grant_pipe;
    logic             w_grant_aux;
    logic             w_nonempty_next;
    logic             w_force_next;

    assign w_preq    = pipe_valid & pipe_we & ~stall_in & (pipe_rd != 5'd0);
    assign aux_ready = ~w_full;
    assign w_push    = aux_valid & aux_ready & (aux_rd != 5'd0);
    assign w_pop     = w_grant_aux;
    assign w_aux_req = '{rd: aux_rd, data: aux_data};

    // An x0 aux result is accepted (aux_ready handshake) but never stored
    wb_aux_fifo #(
        .AUX_DEPTH(AUX_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (w_push),
        .pop  (w_pop),
        .din  (w_aux_req),
        .dout (w_head),
        .full (w_full),
        .empty(w_empty),
        .count(w_count)
    );

    assign w_nonempty_next = w_push | (~w_empty & ~(w_pop & (w_count == CNT_W'(1))));

    // Port grant for the current cycle
    always_comb begin
        w_grant_pipe = 1'b0;
        w_grant_aux  = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                w_grant_pipe = w_preq;
            end
            ARB_PEND: begin
                if (w_preq) begin
                    w_grant_pipe = 1'b1;
                end else begin
                    w_grant_aux = ~w_empty;
                end
            end
`ifdef WB_ARB_AGE_EN
            ARB_FORCE: begin
                w_grant_aux = ~w_empty;
            end
`endif
            default: begin
                w_grant_pipe = 1'b0;
                w_grant_aux  = 1'b0;
            end
        endcase
    end

`ifdef WB_ARB_AGE_EN
    localparam int unsigned     AGE_W    = $clog2(MAX_WAIT + 1);
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(MAX_WAIT - 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(MAX_WAIT);

    logic [AGE_W-1:0] r_age;
    logic             w_head_lost;

    assign w_head_lost  = (r_state == ARB_PEND) & w_grant_pipe & ~w_empty;
    assign w_force_next = w_head_lost & (r_age == AGE_LAST);
    assign pipe_stall   = w_preq & w_grant_aux;

    // Consecutive losses of the current head entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_age <= {AGE_W{1'b0}};
        end else if ((r_state == ARB_IDLE) || w_pop) begin
            r_age <= {AGE_W{1'b0}};
        end else if (w_head_lost && (r_age != AGE_MAX)) begin
            r_age <= r_age + {{(AGE_W-1){1'b0}}, 1'b1};
        end else begin
            r_age <= r_age;
        end
    end
`else
    assign w_force_next = 1'b0;
    assign pipe_stall   = 1'b0;
`endif

    // Arbitration FSM, tracking FIFO occupancy after this cycle's push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            case (r_state)
                ARB_IDLE:  r_state <= w_nonempty_next ? ARB_PEND : ARB_IDLE;
                ARB_PEND:  r_state <= w_force_next ? ARB_FORCE :
                                      (w_nonempty_next ? ARB_PEND : ARB_IDLE);
                ARB_FORCE: r_state <= w_nonempty_next ? ARB_PEND : ARB_IDLE;
                default:   r_state <= ARB_IDLE;
            endcase
        end
    end

    // Regfile write port driven straight from the grant
    always_comb begin
        rf_we   = 1'b0;
        rf_rd   = 5'd0;
        rf_data = 32'd0;
        if (w_grant_aux) begin
            rf_we   = 1'b1;
            rf_rd   = w_head.rd;
            rf_data = w_head.data;
        end else if (w_grant_pipe) begin
            rf_we   = 1'b1;
            rf_rd   = pipe_rd;
            rf_data = pipe_data;
        end else begin
            rf_we   = 1'b0;
            rf_rd   = 5'd0;
            rf_data = 32'd0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, table-driven bench for wb_port_arbiter (AUX_DEPTH=2, MAX_WAIT=4),
// with hand-written sequences for contention/aging and reset mid-drain.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in;
    logic        pipe_valid;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        aux_valid;
    logic [4:0]  aux_rd;
    logic [31:0] aux_data;
    logic        aux_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        st;
        logic        pv;
        logic        pw;
        logic [4:0]  prd;
        logic [31:0] pd;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        ew;
        logic [4:0]  erd;
        logic [31:0] ed;
        logic        es;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    wb_port_arbiter #(
        .AUX_DEPTH(2),
        .MAX_WAIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall_in  (stall_in),
        .pipe_valid(pipe_valid),
        .pipe_we   (pipe_we),
        .pipe_rd   (pipe_rd),
        .pipe_data (pipe_data),
        .pipe_stall(pipe_stall),
        .aux_valid (aux_valid),
        .aux_rd    (aux_rd),
        .aux_data  (aux_data),
        .aux_ready (aux_ready),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_data   (rf_data)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic pv, input logic pw,
                                input logic [4:0] prd, input logic [31:0] pd,
                                input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                                input logic es, input logic er);
        vec_t v;
        v = '{st: st, pv: pv, pw: pw, prd: prd, pd: pd, av: av, ard: ard, ad: ad,
              ew: ew, erd: erd, ed: ed, es: es, er: er};
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input int idx,
                              input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                              input logic es, input logic er);
        check({name, ".rf_we"}, idx, {31'd0, rf_we}, {31'd0, ew});
        check({name, ".rf_rd"}, idx, {27'd0, rf_rd}, {27'd0, erd});
        check({name, ".rf_data"}, idx, rf_data, ed);
        check({name, ".pipe_stall"}, idx, {31'd0, pipe_stall}, {31'd0, es});
        check({name, ".aux_ready"}, idx, {31'd0, aux_ready}, {31'd0, er});
    endtask

    task automatic drive(input logic st, input logic pv, input logic pw,
                         input logic [4:0] prd, input logic [31:0] pd,
                         input logic av, input logic [4:0] ard, input logic [31:0] ad);
        stall_in   = st;
        pipe_valid = pv;
        pipe_we    = pw;
        pipe_rd    = prd;
        pipe_data  = pd;
        aux_valid  = av;
        aux_rd     = ard;
        aux_data   = ad;
    endtask

    // One cycle: drive after the rising edge, check at the falling edge
    task automatic cyc(input logic st, input logic pv, input logic pw,
                       input logic [4:0] prd, input logic [31:0] pd,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input string name, input int idx,
                       input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                       input logic es, input logic er);
        @(posedge clk);
        #1;
        drive(st, pv, pw, prd, pd, av, ard, ad);
        @(negedge clk);
        check_outs(name, idx, ew, erd, ed, es, er);
    endtask

    initial begin
        // st pv pw prd pd | av ard ad | ew erd ed es er
        vecs.push_back(mk(1'b0,1'b0,1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,5'd0,32'h0,     1'b1,5'd5,32'h1234,  1'b0,5'd0,32'h0,     1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b1,5'd5,32'h1234,  1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,5'd0,32'h0,     1'b1,5'd0,32'hDEAD,  1'b0,5'd0,32'h0,     1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,5'd0,32'h0,     1'b1,5'd9,32'h99,    1'b0,5'd0,32'h0,     1'b0,1'b1));
        vecs.push_back(mk(1'b1,1'b1,1'b1,5'd3,32'hAA,    1'b0,5'd0,32'h0,     1'b1,5'd9,32'h99,    1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,5'd0,32'h55,    1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,5'd3,32'hAA,    1'b0,5'd0,32'h0,     1'b1,5'd3,32'hAA,    1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b0,5'd4,32'h44,    1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,5'd3,32'hAA,    1'b1,5'd11,32'h1,    1'b1,5'd3,32'hAA,    1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,5'd3,32'hAA,    1'b1,5'd12,32'h2,    1'b1,5'd3,32'hAA,    1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,5'd3,32'hAA,    1'b1,5'd13,32'h3,    1'b1,5'd3,32'hAA,    1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,5'd0,32'h0,     1'b1,5'd13,32'h3,    1'b1,5'd11,32'h1,    1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,5'd0,32'h0,     1'b1,5'd13,32'h3,    1'b1,5'd12,32'h2,    1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b1,5'd13,32'h3,    1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,5'd0,32'h0,     1'b1,5'd1,32'h101,   1'b0,5'd0,32'h0,     1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,5'd0,32'h0,     1'b1,5'd2,32'h102,   1'b1,5'd1,32'h101,   1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,5'd0,32'h0,     1'b1,5'd3,32'h103,   1'b1,5'd2,32'h102,   1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,5'd0,32'h0,     1'b1,5'd4,32'h104,   1'b1,5'd3,32'h103,   1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,5'd0,32'h0,     1'b1,5'd5,32'h105,   1'b1,5'd4,32'h104,   1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b1,5'd5,32'h105,   1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b0,1'b1));

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs("reset_hold", 0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_outs("reset_release", 0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].st, vecs[i].pv, vecs[i].pw, vecs[i].prd, vecs[i].pd,
                vecs[i].av, vecs[i].ard, vecs[i].ad, "vec", i,
                vecs[i].ew, vecs[i].erd, vecs[i].ed, vecs[i].es, vecs[i].er);
        end

        // Contention: rd=7 queued while the pipe writes rd=3 every cycle
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77,
            "cont_push", 0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
`ifdef WB_ARB_AGE_EN
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 32'h0,
                "cont_pipe", i, 1'b1, 5'd3, 32'hAA, 1'b0, 1'b1);
        end
        cyc(1'b0, 1'b1, 1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 32'h0,
            "cont_force", 0, 1'b1, 5'd7, 32'h77, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 32'h0,
            "cont_resume", 0, 1'b1, 5'd3, 32'hAA, 1'b0, 1'b1);
`else
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 32'h0,
                "cont_pipe", i, 1'b1, 5'd3, 32'hAA, 1'b0, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
            "cont_drain", 0, 1'b1, 5'd7, 32'h77, 1'b0, 1'b1);
`endif
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
            "cont_empty", 0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

        // Reset with two entries queued, asserted while draining
        cyc(1'b0, 1'b1, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd20, 32'h20,
            "rstmid_push", 0, 1'b1, 5'd3, 32'hAA, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd21, 32'h21,
            "rstmid_push", 1, 1'b1, 5'd3, 32'hAA, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
            "rstmid_drain", 0, 1'b1, 5'd20, 32'h20, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_outs("rstmid_hold", 0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                "rstmid_after", i, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
